alu_operand_stage: RTL and testbench

Sequential front/back stage of the generalized ALU. It loads operand A, operand B and the opcode, one at a time, from a shared data bus using a load strobe. It holds them stable on the inputs of the combinational operation units and their result mux. It then registers the selected result together with status flags for display.

---
 rtl/alu_operand_stage.sv | 113 +++++++++++
 tb/tb_alu_operand_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Operand/opcode capture and result registration around the combinational ALU.
// Loads A, B and the opcode from a shared bus, then latches the result and {N,Z,C,V}.
module alu_operand_stage #(
  parameter int n_bits  = 8,
  parameter int op_bits = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [n_bits-1:0]  dato_in,
  input  logic               cargar,
  input  logic [n_bits-1:0]  resultado_alu,
  input  logic               carry_alu,
  input  logic               overflow_alu,
  output logic [n_bits-1:0]  entrada_a,
  output logic [n_bits-1:0]  entrada_b,
  output logic [op_bits-1:0] opcode,
  output logic [n_bits-1:0]  resultado,
  output logic [3:0]         flags,
  output logic               valido,
  output logic [2:0]         estado
);

  typedef enum logic [2:0] {
    ESPERA_A  = 3'd0,
    ESPERA_B  = 3'd1,
    ESPERA_OP = 3'd2,
    CALCULA   = 3'd3,
    MUESTRA   = 3'd4
  } estado_t;

  estado_t             st_q, st_nx;
  logic [n_bits-1:0]   a_q, a_nx;
  logic [n_bits-1:0]   b_q, b_nx;
  logic [op_bits-1:0]  op_q, op_nx;
  logic [n_bits-1:0]   res_q, res_nx;
  logic [3:0]          fl_q, fl_nx;
  logic                val_q, val_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= ESPERA_A;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
      fl_q  <= '0;
      val_q <= 1'b0;
    end else begin
      st_q  <= st_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      op_q  <= op_nx;
      res_q <= res_nx;
      fl_q  <= fl_nx;
      val_q <= val_nx;
    end
  end

  always_comb begin
    st_nx  = st_q;
    a_nx   = a_q;
    b_nx   = b_q;
    op_nx  = op_q;
    res_nx = res_q;
    fl_nx  = fl_q;
    val_nx = val_q;
    case (st_q)
      ESPERA_A: begin
        if (cargar) begin
          a_nx  = dato_in;
          st_nx = ESPERA_B;
        end
      end
      ESPERA_B: begin
        if (cargar) begin
          b_nx  = dato_in;
          st_nx = ESPERA_OP;
        end
      end
      ESPERA_OP: begin
        if (cargar) begin
          op_nx = dato_in[op_bits-1:0];
          st_nx = CALCULA;
        end
      end
      CALCULA: begin
        // Single cycle; a strobe arriving here is deliberately dropped.
        res_nx = resultado_alu;
        fl_nx  = {resultado_alu[n_bits-1], (resultado_alu == '0), carry_alu, overflow_alu};
        val_nx = 1'b1;
        st_nx  = MUESTRA;
      end
      MUESTRA: begin
        // A new A starts the next operation; old result stays visible until CALCULA.
        if (cargar) begin
          a_nx   = dato_in;
          val_nx = 1'b0;
          st_nx  = ESPERA_B;
        end
      end
      default: st_nx = ESPERA_A;
    endcase
  end

  assign entrada_a = a_q;
  assign entrada_b = b_q;
  assign opcode    = op_q;
  assign resultado = res_q;
  assign flags     = fl_q;
  assign valido    = val_q;
  assign estado    = st_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with an AND-based stand-in for the ALU mux.
module tb_alu_operand_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dato_in;
  logic       cargar;
  logic [7:0] resultado_alu;
  logic       carry_alu;
  logic       overflow_alu;
  logic [7:0] entrada_a;
  logic [7:0] entrada_b;
  logic [2:0] opcode;
  logic [7:0] resultado;
  logic [3:0] flags;
  logic       valido;
  logic [2:0] estado;

  logic       alu_ovr;
  logic [7:0] alu_val;
  logic       alu_c;
  logic       alu_v;

  int unsigned tests = 0;
  int unsigned fails = 0;

  alu_operand_stage #(.n_bits(8), .op_bits(3)) dut (
    .clk(clk),
    .reset(reset),
    .dato_in(dato_in),
    .cargar(cargar),
    .resultado_alu(resultado_alu),
    .carry_alu(carry_alu),
    .overflow_alu(overflow_alu),
    .entrada_a(entrada_a),
    .entrada_b(entrada_b),
    .opcode(opcode),
    .resultado(resultado),
    .flags(flags),
    .valido(valido),
    .estado(estado)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: A & B with C=V=0 unless a directed override is active.
  always_comb begin
    resultado_alu = alu_ovr ? alu_val : (entrada_a & entrada_b);
    carry_alu     = alu_ovr ? alu_c : 1'b0;
    overflow_alu  = alu_ovr ? alu_v : 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    dato_in = d;
    cargar  = 1'b1;
    tick();
    cargar  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cargar = 1'b0; dato_in = '0;
    alu_ovr = 1'b0; alu_val = '0; alu_c = 1'b0; alu_v = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_a", entrada_a, 0);
    check("rst_b", entrada_b, 0);
    check("rst_op", opcode, 0);
    check("rst_res", resultado, 0);
    check("rst_flags", flags, 0);
    check("rst_valido", valido, 0);
    check("rst_estado", estado, 0);

    // Idle hold without strobe
    tick(); tick();
    check("idle_estado", estado, 0);

    // F0 & 3C = 30
    load(8'hF0);
    check("t1_a", entrada_a, 8'hF0);
    check("t1_st_b", estado, 1);
    tick();
    check("t1_hold_b", estado, 1);
    load(8'h3C);
    check("t1_b", entrada_b, 8'h3C);
    check("t1_st_op", estado, 2);
    load(8'h02);
    check("t1_op", opcode, 2);
    check("t1_st_calc", estado, 3);
    check("t1_val_calc", valido, 0);
    tick();
    check("t1_res", resultado, 8'h30);
    check("t1_flags", flags, 4'b0000);
    check("t1_valido", valido, 1);
    check("t1_estado", estado, 4);
    tick(); tick();
    check("t1_hold_st", estado, 4);
    check("t1_hold_res", resultado, 8'h30);

    // 0F & F0 = 00 -> Z; opcode upper bits dropped (FA -> 2)
    load(8'h0F);
    check("t2_st", estado, 1);
    check("t2_val", valido, 0);
    check("t2_res_kept", resultado, 8'h30);
    load(8'hF0);
    load(8'hFA);
    check("t2_op", opcode, 2);
    tick();
    check("t2_res", resultado, 8'h00);
    check("t2_flags", flags, 4'b0100);

    // 80 & FF = 80 -> N
    load(8'h80);
    load(8'hFF);
    load(8'h01);
    check("t3_op", opcode, 1);
    tick();
    check("t3_res", resultado, 8'h80);
    check("t3_flags", flags, 4'b1000);

    // Forced ALU outputs: 7F with C=V=1
    load(8'h01);
    load(8'h02);
    load(8'h03);
    alu_ovr = 1'b1; alu_val = 8'h7F; alu_c = 1'b1; alu_v = 1'b1;
    tick();
    alu_ovr = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
    check("t4_res", resultado, 8'h7F);
    check("t4_flags", flags, 4'b0011);

    // Strobe during CALCULA is ignored
    load(8'hC3);
    load(8'h0F);
    load(8'h00);
    check("t5_st_calc", estado, 3);
    load(8'h99);
    check("t5_estado", estado, 4);
    check("t5_res", resultado, 8'h03);
    check("t5_flags", flags, 4'b0000);
    check("t5_a", entrada_a, 8'hC3);
    check("t5_valido", valido, 1);

    // MUESTRA strobe starts a new operation
    load(8'h55);
    check("t6_a", entrada_a, 8'h55);
    check("t6_valido", valido, 0);
    check("t6_estado", estado, 1);
    check("t6_res", resultado, 8'h03);

    // Held cargar counts each cycle: two cycles load B then opcode
    dato_in = 8'h06; cargar = 1'b1;
    tick(); tick();
    cargar = 1'b0;
    check("t7_b", entrada_b, 8'h06);
    check("t7_op", opcode, 6);
    check("t7_st", estado, 3);
    tick();
    check("t7_res", resultado, 8'h04);

    // Reset mid-operation with cargar high
    load(8'hAA);
    load(8'h11);
    check("t8_st_op", estado, 2);
    reset = 1'b1; cargar = 1'b1; dato_in = 8'h77;
    tick();
    reset = 1'b0; cargar = 1'b0;
    check("t8_a", entrada_a, 0);
    check("t8_b", entrada_b, 0);
    check("t8_op", opcode, 0);
    check("t8_res", resultado, 0);
    check("t8_flags", flags, 0);
    check("t8_valido", valido, 0);
    check("t8_estado", estado, 0);
    load(8'h42);
    check("t8_reload_a", entrada_a, 8'h42);
    check("t8_reload_st", estado, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
